// File: rtl/cpu_int_responder.sv
// ----------------------------------------------------------------------------
// cpu_int_responder
//
// CPU-side endpoint of the interrupt request/acknowledge handshake. Samples
// the controller's request line, waits in DRAIN for a clean instruction
// boundary, then spends exactly one TAKE cycle acknowledging the controller,
// flushing younger stages and redirecting fetch to the vector register. The
// return PC is captured into epc. Further requests are masked in HANDLER
// until reti. After reti, a short hold-off lets one instruction retire
// before re-entry is allowed.
//
// Parameters:
//   DEFAULT_IVEC   vector address loaded at reset
//   HOLDOFF        cycles after reti during which the request is ignored (0..15)
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous reset, active low
//   int_req        interrupt request from controller; level, held until acked
//                  (the controller's "int" line; int is a reserved word in SV)
//   int_ack        one-cycle acknowledge to controller
//   retire_valid   an instruction retires this cycle
//   retire_pc      PC of the instruction following the retiring one
//   stall          pipeline stalled this cycle
//   branch_pending branch/delay-slot pair in flight; not an interrupt boundary
//   reti           return-from-interrupt retiring this cycle
//   ivec_we        write enable for the vector register
//   ivec_din       new vector address (bits [1:0] are forced to zero)
//   flush          flush younger pipeline stages
//   redirect       fetch must load redirect_pc
//   redirect_pc    handler address, held between takes
//   epc            saved return PC
//   in_handler     handler active; nested interrupts blocked
// ----------------------------------------------------------------------------
module cpu_int_responder #(
   parameter logic [31:0] DEFAULT_IVEC = 32'h0000_0100,
   parameter int unsigned HOLDOFF      = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        int_req,
   output logic        int_ack,
   input  logic        retire_valid,
   input  logic [31:0] retire_pc,
   input  logic        stall,
   input  logic        branch_pending,
   input  logic        reti,
   input  logic        ivec_we,
   input  logic [31:0] ivec_din,
   output logic        flush,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic [31:0] epc,
   output logic        in_handler
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_DRAIN   = 2'd1;
   localparam logic [1:0] S_TAKE    = 2'd2;
   localparam logic [1:0] S_HANDLER = 2'd3;

   localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;
   localparam logic [31:0] RESET_IVEC   = DEFAULT_IVEC & ALIGN_MASK;
   localparam logic [3:0]  HOLDOFF_INIT = 4'(HOLDOFF);

   logic [1:0]  state, state_nx;
   logic [3:0]  holdoff, holdoff_nx;
   logic [31:0] ivec;
   logic        qualify;
   logic        take;

   // A clean boundary: something retires, nothing holds the pipe, and we
   // are not splitting a branch from its delay slot.
   assign qualify = retire_valid & ~stall & ~branch_pending;

   // NOTE: every signal driven here gets a default first so no path through
   // the case statement leaves it unassigned (which would infer a latch).
   always_comb begin
      state_nx   = state;
      holdoff_nx = holdoff;
      take       = 1'b0;
      case (state)
         S_IDLE: begin
            if (holdoff != 4'd0) begin
               holdoff_nx = holdoff - 4'd1;
            end else if (int_req) begin
               state_nx = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // A withdrawn request beats a simultaneous boundary.
            if (!int_req) begin
               state_nx = S_IDLE;
            end else if (qualify) begin
               state_nx = S_TAKE;
               take     = 1'b1;
            end
         end
         S_TAKE: begin
            state_nx = S_HANDLER;
         end
         S_HANDLER: begin
            if (reti) begin
               state_nx   = S_IDLE;
               holdoff_nx = HOLDOFF_INIT;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next-state decode so they line up
   // exactly with the state they describe and are glitch-free.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         holdoff     <= 4'd0;
         ivec        <= RESET_IVEC;
         int_ack     <= 1'b0;
         flush       <= 1'b0;
         redirect    <= 1'b0;
         in_handler  <= 1'b0;
         redirect_pc <= 32'd0;
         epc         <= 32'd0;
      end else begin
         state      <= state_nx;
         holdoff    <= holdoff_nx;
         int_ack    <= (state_nx == S_TAKE);
         flush      <= (state_nx == S_TAKE);
         redirect   <= (state_nx == S_TAKE);
         in_handler <= (state_nx == S_HANDLER);
         // redirect_pc latches the vector as it stands on entry to TAKE, so
         // a write landing during TAKE only affects the next interrupt.
         if (take) begin
            epc         <= retire_pc;
            redirect_pc <= ivec;
         end
         if (ivec_we) begin
            ivec <= ivec_din & ALIGN_MASK;
         end
      end
   end

endmodule

// File: tb/tb_cpu_int_responder.sv
// ----------------------------------------------------------------------------
// tb_cpu_int_responder
//
// Directed bench for cpu_int_responder with the default parameters
// (DEFAULT_IVEC = 0x100, HOLDOFF = 1). Inputs change 1 ns after the rising
// edge and outputs are sampled at the same point, well away from the edge.
// ----------------------------------------------------------------------------
module tb_cpu_int_responder;

   logic        clk;
   logic        rst;
   logic        int_req;
   logic        int_ack;
   logic        retire_valid;
   logic [31:0] retire_pc;
   logic        stall;
   logic        branch_pending;
   logic        reti;
   logic        ivec_we;
   logic [31:0] ivec_din;
   logic        flush;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] epc;
   logic        in_handler;

   int vectors     = 0;
   int miscompares = 0;

   cpu_int_responder dut (
      .clk            (clk),
      .rst            (rst),
      .int_req        (int_req),
      .int_ack        (int_ack),
      .retire_valid   (retire_valid),
      .retire_pc      (retire_pc),
      .stall          (stall),
      .branch_pending (branch_pending),
      .reti           (reti),
      .ivec_we        (ivec_we),
      .ivec_din       (ivec_din),
      .flush          (flush),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .epc            (epc),
      .in_handler     (in_handler)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      int_req        = 1'b0;
      retire_valid   = 1'b0;
      retire_pc      = 32'd0;
      stall          = 1'b0;
      branch_pending = 1'b0;
      reti           = 1'b0;
      ivec_we        = 1'b0;
      ivec_din       = 32'd0;
   endtask

   task automatic check_take_pulse(input string tag, input logic exp);
      check({tag, "_ack"},      32'(int_ack),  32'(exp));
      check({tag, "_flush"},    32'(flush),    32'(exp));
      check({tag, "_redirect"}, 32'(redirect), 32'(exp));
   endtask

   initial begin
      rst = 1'b0;
      clear_inputs();
      tick();
      tick();

      // ---- reset values ----
      check_take_pulse("rst0", 1'b0);
      check("rst0_in_handler", 32'(in_handler), 32'd0);
      check("rst0_epc",        epc,             32'd0);
      check("rst0_rpc",        redirect_pc,     32'd0);

      // ---- 1: reset asserted during TAKE ----
      rst          = 1'b1;
      int_req      = 1'b1;
      retire_valid = 1'b1;
      retire_pc    = 32'h0000_1000;
      tick();                                   // IDLE -> DRAIN
      check("t1_drain_ack", 32'(int_ack), 32'd0);
      tick();                                   // DRAIN -> TAKE
      check_take_pulse("t1_take", 1'b1);
      check("t1_take_rpc", redirect_pc, 32'h0000_0100);
      check("t1_take_epc", epc,         32'h0000_1000);
      rst = 1'b0;                               // asynchronous, mid-TAKE
      clear_inputs();
      #1;
      check_take_pulse("t1_async", 1'b0);
      check("t1_async_epc", epc,         32'd0);
      check("t1_async_rpc", redirect_pc, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_take_pulse("t1_hold", 1'b0);
         check("t1_hold_in_handler", 32'(in_handler), 32'd0);
      end
      check("t1_hold_epc", epc,         32'd0);
      check("t1_hold_rpc", redirect_pc, 32'd0);
      rst = 1'b1;
      int_req      = 1'b1;
      retire_valid = 1'b1;
      retire_pc    = 32'h0000_1100;
      tick();
      check("t1_post_drain_ack", 32'(int_ack), 32'd0);
      tick();
      check_take_pulse("t1_post_take", 1'b1);
      check("t1_post_rpc", redirect_pc, 32'h0000_0100);
      check("t1_post_epc", epc,         32'h0000_1100);
      clear_inputs();
      tick();                                   // HANDLER
      check_take_pulse("t1_post_handler", 1'b0);
      check("t1_post_in_handler", 32'(in_handler), 32'd1);
      check("t1_post_rpc_hold",   redirect_pc,     32'h0000_0100);
      reti = 1'b1;
      tick();                                   // IDLE, holdoff 1
      reti = 1'b0;
      check("t1_reti_in_handler", 32'(in_handler), 32'd0);
      tick();                                   // holdoff -> 0

      // ---- 2: basic take with a written vector ----
      ivec_we  = 1'b1;
      ivec_din = 32'h0000_0200;
      tick();
      ivec_we  = 1'b0;
      int_req  = 1'b1;
      tick();                                   // IDLE -> DRAIN
      check("t2_drain_ack", 32'(int_ack), 32'd0);
      retire_valid = 1'b1;
      retire_pc    = 32'h0000_1004;
      tick();                                   // DRAIN -> TAKE
      check_take_pulse("t2_take", 1'b1);
      check("t2_rpc", redirect_pc, 32'h0000_0200);
      check("t2_epc", epc,         32'h0000_1004);
      retire_valid = 1'b0;
      tick();                                   // HANDLER
      check_take_pulse("t2_handler", 1'b0);
      check("t2_in_handler", 32'(in_handler), 32'd1);

      // ---- 4: nesting blocked, then hold-off after reti ----
      retire_valid = 1'b1;
      retire_pc    = 32'h0000_3000;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t4_nest_ack",        32'(int_ack),    32'd0);
         check("t4_nest_in_handler", 32'(in_handler), 32'd1);
      end
      check("t4_nest_epc", epc, 32'h0000_1004);
      reti = 1'b1;
      tick();                                   // edge A: IDLE, holdoff 1
      reti = 1'b0;
      check("t4_a_ack",        32'(int_ack),    32'd0);
      check("t4_a_in_handler", 32'(in_handler), 32'd0);
      tick();                                   // edge B: holdoff 0, int ignored
      check("t4_b_ack", 32'(int_ack), 32'd0);
      tick();                                   // edge C: DRAIN
      check("t4_c_ack", 32'(int_ack), 32'd0);
      check("t4_c_epc", epc,          32'h0000_1004);
      tick();                                   // edge D: TAKE
      check("t4_d_ack", 32'(int_ack), 32'd1);
      check("t4_d_epc", epc,          32'h0000_3000);
      clear_inputs();
      tick();                                   // HANDLER
      reti = 1'b1;
      tick();
      reti = 1'b0;
      tick();

      // ---- 3: drain blocked by stall and branch_pending ----
      int_req      = 1'b1;
      retire_valid = 1'b1;
      retire_pc    = 32'hDEAD_0000;
      stall        = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t3_stall_ack", 32'(int_ack), 32'd0);
      end
      stall          = 1'b0;
      branch_pending = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("t3_branch_ack", 32'(int_ack), 32'd0);
      end
      check("t3_blocked_epc", epc, 32'h0000_3000);
      branch_pending = 1'b0;
      retire_pc      = 32'h0000_2008;
      tick();
      check_take_pulse("t3_take", 1'b1);
      check("t3_epc", epc,         32'h0000_2008);
      check("t3_rpc", redirect_pc, 32'h0000_0200);
      clear_inputs();
      tick();
      reti = 1'b1;
      tick();
      reti = 1'b0;
      tick();

      // ---- 5: withdrawn request ----
      int_req = 1'b1;
      tick();                                   // DRAIN, no retire
      int_req = 1'b0;
      tick();                                   // back to IDLE
      check("t5_ack0", 32'(int_ack), 32'd0);
      tick();
      check("t5_ack1", 32'(int_ack), 32'd0);
      check("t5_epc",  epc,          32'h0000_2008);
      // Withdrawal coinciding with a clean boundary: the withdrawal wins.
      int_req = 1'b1;
      tick();                                   // DRAIN
      int_req      = 1'b0;
      retire_valid = 1'b1;
      retire_pc    = 32'h0000_5550;
      tick();
      check("t5_race_ack", 32'(int_ack), 32'd0);
      check("t5_race_epc", epc,          32'h0000_2008);
      tick();
      check("t5_race_ack2",       32'(int_ack),    32'd0);
      check("t5_race_in_handler", 32'(in_handler), 32'd0);
      clear_inputs();

      // ---- 6: vector write during TAKE ----
      int_req      = 1'b1;
      retire_valid = 1'b1;
      retire_pc    = 32'h0000_6000;
      tick();                                   // DRAIN
      tick();                                   // TAKE
      check("t6_take_ack", 32'(int_ack), 32'd1);
      check("t6_take_rpc", redirect_pc,  32'h0000_0200);
      clear_inputs();
      ivec_we  = 1'b1;
      ivec_din = 32'h0000_0303;
      tick();                                   // HANDLER; ivec written
      ivec_we  = 1'b0;
      check("t6_handler_rpc", redirect_pc,     32'h0000_0200);
      check("t6_handler_ack", 32'(int_ack),    32'd0);
      check("t6_in_handler",  32'(in_handler), 32'd1);
      reti = 1'b1;
      tick();
      reti = 1'b0;
      tick();
      int_req      = 1'b1;
      retire_valid = 1'b1;
      retire_pc    = 32'h0000_7000;
      tick();
      tick();
      check_take_pulse("t6_next", 1'b1);
      check("t6_next_rpc", redirect_pc, 32'h0000_0300);
      check("t6_next_epc", epc,         32'h0000_7000);
      clear_inputs();
      tick();
      check_take_pulse("t6_after", 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cpu_int_responder.md
Name: cpu_int_responder

Overview:
- CPU-side endpoint of the interrupt request/acknowledge handshake.
- Samples the controller's int line and waits for a clean instruction boundary.
- Acknowledges with a single-cycle int_ack, saves the return PC into epc, and redirects fetch to a programmable vector.
- Masks further requests until the handler executes a return-from-interrupt; sits between the interrupt controller and the fetch/retire logic.

Parameters:
DEFAULT_IVEC, 32'h00000100, vector address loaded at reset
HOLDOFF, 1, cycles after reti during which int is ignored (0..15; lets one instruction retire before re-entry)

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  reset, asynchronous, active-low
int  in  1  interrupt request from controller; level, held until acked
int_ack  out  1  one-cycle acknowledge to controller
retire_valid  in  1  an instruction retires this cycle
retire_pc  in  32  PC of next instruction after the retiring one
stall  in  1  pipeline stalled this cycle
branch_pending  in  1  branch/delay-slot pair in flight; no interrupt boundary
reti  in  1  return-from-interrupt retiring this cycle
ivec_we  in  1  write enable for vector register
ivec_din  in  32  new vector address
flush  out  1  flush younger pipeline stages
redirect  out  1  fetch must load redirect_pc
redirect_pc  out  32  handler address
epc  out  32  saved return PC
in_handler  out  1  handler active; nested interrupts blocked

Behaviour:
- Reset (rst low, asynchronous, any state):
  - State IDLE; holdoff counter 0; ivec = DEFAULT_IVEC.
  - int_ack, flush, redirect, in_handler = 0; redirect_pc = 0; epc = 0.
- All state updates on rising clk. int is treated as synchronous; the controller updates it on the falling edge.
- FSM states: IDLE, DRAIN, TAKE, HANDLER.
- IDLE:
  - holdoff != 0: decrement by 1; int ignored.
  - holdoff == 0 and int = 1: go to DRAIN.
- DRAIN:
  - Qualifying cycle = retire_valid & !stall & !branch_pending. On one: epc <= retire_pc; go to TAKE.
  - int = 0 with no qualifying cycle: return to IDLE. No ack; epc unchanged.
  - Qualifying cycle and int = 0 together: int wins; return to IDLE.
- TAKE: exactly one cycle.
  - int_ack = flush = redirect = 1; redirect_pc = ivec as registered at entry to TAKE.
  - Unconditionally go to HANDLER.
  - Outputs are registered decodes of state. They are 0 in every other state, except redirect_pc, which holds its last value.
- HANDLER:
  - in_handler = 1; int ignored.
  - reti = 1: go to IDLE; holdoff <= HOLDOFF; in_handler drops the following cycle.
- reti outside HANDLER: ignored.
- Latency: minimum 2 rising edges from int sampled high (IDLE) to int_ack high.
  - DRAIN is unbounded; it waits for a qualifying cycle.
- ivec register:
  - ivec_we = 1 writes ivec_din at the rising edge, in any state, including TAKE.
  - A write during TAKE does not affect the current redirect_pc; it applies to the next interrupt.
  - Writes are word-aligned; bits [1:0] are forced to 0.
- epc:
  - Written only on DRAIN→TAKE.
  - Stable through HANDLER and after return, until the next take.
- Reset asserted mid-operation (DRAIN/TAKE/HANDLER): immediate return to reset values.
  - No partial ack pulse survives.
- Implementation size: 120-250 lines RTL; no memories.

Test Plan:
1. Reset: rst low for 3 cycles during TAKE → int_ack, flush, redirect, in_handler, epc, redirect_pc all 0; first interrupt after release vectors to 0x00000100.
2. Basic take:
   - Stimulus: write ivec 0x00000200; raise int; next cycle retire_valid = 1, retire_pc = 0x00001004, stall = 0.
   - Response: int_ack/flush/redirect high exactly one cycle, 2 edges after int sampled; redirect_pc = 0x00000200; epc = 0x00001004; in_handler = 1.
3. Drain blocking:
   - Stimulus: int high; stall = 1 for 5 cycles, then branch_pending = 1 for 2 cycles with retire_valid; then a clean retire with retire_pc = 0x00002008.
   - Response: no int_ack before the clean retire; epc = 0x00002008.
4. Nesting and holdoff:
   - Stimulus: in HANDLER with int held high; pulse reti.
   - Response: no DRAIN while in HANDLER; after reti, IDLE for HOLDOFF = 1 cycle; DRAIN entered on the following edge.
5. Withdrawn request:
   - Stimulus: int high one cycle, then low while in DRAIN with no retire.
   - Response: back to IDLE; int_ack never asserted; epc keeps previous value.
6. Vector write during TAKE:
   - Stimulus: ivec_we = 1, ivec_din = 0x00000303 in the TAKE cycle.
   - Response: redirect_pc = old vector; next interrupt redirects to 0x00000300 (bits [1:0] cleared).
